phase_time_setter: RTL and testbench
====================================

Name: phase_time_setter

Overview:
- Operator-facing writer for the intersection phase durations.
- Takes four raw push-buttons and lets the operator edit green and yellow times for road 1 and road 2.
- Holds the committed durations that the countdown path reads, and issues a one-cycle load pulse on commit.
- Runs in the 50 MHz domain next to the 1 s divider; its outputs feed the countdown/subtractor block. While editing, the field under edit can drive the 7-segment path.

Parameters:
DEB_CYCLES, 1000000, consecutive stable cycles before a button change is accepted (20 ms at 50 MHz)
MIN_SEC, 1, smallest legal duration in seconds
MAX_SEC, 59, largest legal duration in seconds (must fit 6 bits)
DEF_G1, 25, reset green time, road 1
DEF_Y1, 3, reset yellow time, road 1
DEF_G2, 20, reset green time, road 2
DEF_Y2, 3, reset yellow time, road 2

Ports:
clk_50M  in  1  system clock, 50 MHz
rst_n  in  1  reset, asynchronous, active-low
btn_mode_n  in  1  raw mode button, active-low, asynchronous to clock
btn_up_n  in  1  raw increment button, active-low
btn_down_n  in  1  raw decrement button, active-low
btn_save_n  in  1  raw save button, active-low
t_g1  out  6  committed road-1 green seconds
t_y1  out  6  committed road-1 yellow seconds
t_g2  out  6  committed road-2 green seconds
t_y2  out  6  committed road-2 yellow seconds
load  out  1  one-cycle pulse when the t_* outputs take new values
editing  out  1  high in any EDIT state
edit_field  out  2  field selector: 0=G1, 1=Y1, 2=G2, 3=Y2
edit_val  out  6  shadow value of the selected field; 0 when not editing

Behaviour:
Reset values (rst_n low, asynchronous):
- t_g1/t_y1/t_g2/t_y2 = DEF_G1/DEF_Y1/DEF_G2/DEF_Y2.
- load=0, editing=0, edit_field=0, edit_val=0.
- State RUN.
- Debouncers read as released; any shadow edits are discarded.
- Reset asserted mid-edit gives exactly this state.

Input conditioning, per button:
- 2-flop synchroniser, then a debounce counter.
- The debounced level changes only after the synchronised input has differed from it for DEB_CYCLES consecutive cycles. Any bounce restarts the count.
- A press event is a one-cycle pulse on the debounced released-to-pressed transition. Releases generate no event.
- Holding a button produces one event, with no auto-repeat.

Event priority per cycle: save > mode > up > down. Only the highest-priority event is acted on; lower ones in the same cycle are dropped.

FSM states: RUN, EDIT_G1, EDIT_Y1, EDIT_G2, EDIT_Y2, COMMIT.
- RUN:
  - mode event: copy all four committed values into the shadow registers, go to EDIT_G1.
  - up, down and save events are ignored.
- EDIT_x:
  - up: shadow_x+1; MAX_SEC wraps to MIN_SEC.
  - down: shadow_x-1; MIN_SEC wraps to MAX_SEC.
  - mode: advance G1->Y1->G2->Y2. Mode in EDIT_Y2 returns to RUN with the shadow discarded (abort); t_* are unchanged and no load pulse is issued.
  - save: go to COMMIT.
- COMMIT:
  - Lasts exactly one cycle, then RUN.
  - t_* take the shadow values on the same clock edge that enters COMMIT.
  - load=1 only during the COMMIT cycle.
  - Latency: save event in cycle N gives load high and new t_* in cycle N+1.
  - Load is pulsed even if the values are unchanged.
- Outputs during and after an edit:
  - edit_val and edit_field are registered and reflect the shadow in the cycle after an up/down/mode event.
  - t_* never change outside COMMIT or reset.

Arithmetic:
- 6-bit unsigned.
- Shadow values are always within MIN_SEC..MAX_SEC.
- Wrap is checked against the parameters, never by natural 6-bit overflow.

Test Plan:
(All scenarios use DEB_CYCLES=4.)
- Reset: drive rst_n low asynchronously mid-cycle -> t_g1=25, t_y1=3, t_g2=20, t_y2=3, load=0, editing=0, edit_val=0 immediately, with no clock edge required.
- Debounce: a 3-cycle low glitch on btn_up_n during EDIT_G1 -> no change. A clean press held for 10 cycles -> edit_val 25->26 exactly once.
- Edit and commit: mode, up x3, mode, down, then save -> one load pulse one cycle after the save event, t_g1=28, t_y1=2, t_g2=20, t_y2=3.
- Wrap: in EDIT_Y1 starting at 1, down -> 59; then up -> 1. Neither change sets load.
- Abort: mode, up, then mode x4 -> editing returns to 0, t_g1 stays 25, load never asserted.
- Simultaneous and ignored events: save and up events in the same cycle in EDIT_G2 -> commit with the unincremented value. Up, down and save in RUN -> no output change. Reset asserted in EDIT_G2 after edits -> defaults restored and state RUN.

Source files
------------

// File: rtl/phase_time_setter.sv
// Operator editor for the four intersection phase durations: debounced buttons,
// shadow edit registers and a one-cycle load pulse when new values are committed.
module phase_time_setter #(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned MIN_SEC    = 1,
  parameter int unsigned MAX_SEC    = 59,
  parameter int unsigned DEF_G1     = 25,
  parameter int unsigned DEF_Y1     = 3,
  parameter int unsigned DEF_G2     = 20,
  parameter int unsigned DEF_Y2     = 3
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       btn_mode_n,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_save_n,
  output logic [5:0] t_g1,
  output logic [5:0] t_y1,
  output logic [5:0] t_g2,
  output logic [5:0] t_y2,
  output logic       load,
  output logic       editing,
  output logic [1:0] edit_field,
  output logic [5:0] edit_val
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [5:0] MIN6 = 6'(MIN_SEC);
  localparam logic [5:0] MAX6 = 6'(MAX_SEC);
  localparam logic [3:0][5:0] DEF_T = {6'(DEF_Y2), 6'(DEF_G2), 6'(DEF_Y1), 6'(DEF_G1)};

  localparam logic [2:0] ST_RUN     = 3'd0;
  localparam logic [2:0] ST_EDIT_G1 = 3'd1;
  localparam logic [2:0] ST_EDIT_Y1 = 3'd2;
  localparam logic [2:0] ST_EDIT_G2 = 3'd3;
  localparam logic [2:0] ST_EDIT_Y2 = 3'd4;
  localparam logic [2:0] ST_COMMIT  = 3'd5;

  // Button bit order: 0=mode, 1=up, 2=down, 3=save; internally active-high.
  logic [3:0]          w_btn;
  logic [3:0]          r_sync1;
  logic [3:0]          r_sync2;
  logic [3:0]          r_deb;
  logic [3:0]          r_press;
  logic [3:0][CW-1:0]  r_cnt;

  assign w_btn = ~{btn_save_n, btn_down_n, btn_up_n, btn_mode_n};

  // Synchronise, debounce and turn each accepted press into a single pulse.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_press <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == CW'(DEB_CYCLES - 1)) begin
            r_deb[i]   <= r_sync2[i];
            r_cnt[i]   <= '0;
            r_press[i] <= r_sync2[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  logic w_save;
  logic w_mode;
  logic w_up;
  logic w_down;

  assign w_save = r_press[3];
  assign w_mode = r_press[0] & ~r_press[3];
  assign w_up   = r_press[1] & ~r_press[0] & ~r_press[3];
  assign w_down = r_press[2] & ~r_press[1] & ~r_press[0] & ~r_press[3];

  logic [2:0]      r_state;
  logic [3:0][5:0] r_sh;
  logic [3:0][5:0] r_t;
  logic            r_load;
  logic            r_editing;
  logic [1:0]      r_field;
  logic [5:0]      r_val;

  logic [2:0]      w_state_nxt;
  logic [3:0][5:0] w_sh_nxt;
  logic [3:0][5:0] w_t_nxt;
  logic [1:0]      w_field;
  logic            w_editing_nxt;
  logic [1:0]      w_field_nxt;
  logic [5:0]      w_val_nxt;
  logic            w_load_nxt;

  assign w_field = 2'(r_state - 3'd1);

  // Next state, shadow/committed values and registered-output precursors.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_t_nxt     = r_t;
    case (r_state)
      ST_RUN: begin
        if (w_mode) begin
          w_sh_nxt    = r_t;
          w_state_nxt = ST_EDIT_G1;
        end
      end
      ST_EDIT_G1, ST_EDIT_Y1, ST_EDIT_G2, ST_EDIT_Y2: begin
        if (w_save) begin
          w_t_nxt     = r_sh;
          w_state_nxt = ST_COMMIT;
        end else if (w_mode) begin
          w_state_nxt = (r_state == ST_EDIT_Y2) ? ST_RUN : r_state + 3'd1;
        end else if (w_up) begin
          w_sh_nxt[w_field] = (r_sh[w_field] >= MAX6) ? MIN6 : r_sh[w_field] + 6'd1;
        end else if (w_down) begin
          w_sh_nxt[w_field] = (r_sh[w_field] <= MIN6) ? MAX6 : r_sh[w_field] - 6'd1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase

    w_editing_nxt = (w_state_nxt >= ST_EDIT_G1) && (w_state_nxt <= ST_EDIT_Y2);
    w_field_nxt   = w_editing_nxt ? 2'(w_state_nxt - 3'd1) : 2'd0;
    w_val_nxt     = w_editing_nxt ? w_sh_nxt[w_field_nxt] : 6'd0;
    w_load_nxt    = (w_state_nxt == ST_COMMIT);
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_sh      <= DEF_T;
      r_t       <= DEF_T;
      r_load    <= 1'b0;
      r_editing <= 1'b0;
      r_field   <= 2'd0;
      r_val     <= 6'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_sh      <= w_sh_nxt;
      r_t       <= w_t_nxt;
      r_load    <= w_load_nxt;
      r_editing <= w_editing_nxt;
      r_field   <= w_field_nxt;
      r_val     <= w_val_nxt;
    end
  end

  assign t_g1       = r_t[0];
  assign t_y1       = r_t[1];
  assign t_g2       = r_t[2];
  assign t_y2       = r_t[3];
  assign load       = r_load;
  assign editing    = r_editing;
  assign edit_field = r_field;
  assign edit_val   = r_val;

endmodule

// File: tb/tb_phase_time_setter.sv
// Directed bench for phase_time_setter with a short debounce window.
module tb_phase_time_setter;

  logic       clk_50M = 1'b0;
  logic       rst_n;
  logic       btn_mode_n, btn_up_n, btn_down_n, btn_save_n;
  logic [5:0] t_g1, t_y1, t_g2, t_y2;
  logic       load, editing;
  logic [1:0] edit_field;
  logic [5:0] edit_val;

  int nvec = 0;
  int nerr = 0;
  int load_cnt = 0;
  int lat_mode, lat_save;

  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_UP   = 4'b0010;
  localparam logic [3:0] B_DOWN = 4'b0100;
  localparam logic [3:0] B_SAVE = 4'b1000;

  phase_time_setter #(
    .DEB_CYCLES(4), .MIN_SEC(1), .MAX_SEC(59),
    .DEF_G1(25), .DEF_Y1(3), .DEF_G2(20), .DEF_Y2(3)
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n),
    .btn_mode_n(btn_mode_n), .btn_up_n(btn_up_n),
    .btn_down_n(btn_down_n), .btn_save_n(btn_save_n),
    .t_g1(t_g1), .t_y1(t_y1), .t_g2(t_g2), .t_y2(t_y2),
    .load(load), .editing(editing), .edit_field(edit_field), .edit_val(edit_val)
  );

  always #5 clk_50M = ~clk_50M;

  always @(negedge clk_50M) if (load === 1'b1) load_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] m);
    {btn_save_n, btn_down_n, btn_up_n, btn_mode_n} = ~m;
  endtask

  task automatic press(input logic [3:0] m);
    @(negedge clk_50M);
    drive(m);
    repeat (10) @(negedge clk_50M);
    drive(4'b0000);
    repeat (12) @(negedge clk_50M);
  endtask

  // Press and count negedges until editing (or load) first rises.
  task automatic press_lat(input logic [3:0] m, input bit watch_load, output int lat);
    lat = 99;
    @(negedge clk_50M);
    drive(m);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_50M);
      if ((watch_load ? load : editing) === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (watch_load) begin
      @(negedge clk_50M);
      chk("load_one_cycle", int'(load), 0);
    end
    repeat (4) @(negedge clk_50M);
    drive(4'b0000);
    repeat (12) @(negedge clk_50M);
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clk_50M);
    #3 rst_n = 1'b0;
    #1;
    chk({tag, "_g1"}, int'(t_g1), 25);
    chk({tag, "_y1"}, int'(t_y1), 3);
    chk({tag, "_g2"}, int'(t_g2), 20);
    chk({tag, "_y2"}, int'(t_y2), 3);
    chk({tag, "_load"}, int'(load), 0);
    chk({tag, "_editing"}, int'(editing), 0);
    chk({tag, "_field"}, int'(edit_field), 0);
    chk({tag, "_val"}, int'(edit_val), 0);
  endtask

  initial begin
    rst_n = 1'b1;
    drive(4'b0000);
    repeat (2) @(negedge clk_50M);
    async_reset_check("reset");
    repeat (2) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50M);

    // Up/down/save while running do nothing.
    press(B_UP); press(B_DOWN); press(B_SAVE);
    chk("run_ign_g1", int'(t_g1), 25);
    chk("run_ign_editing", int'(editing), 0);
    chk("run_ign_load", load_cnt, 0);

    press_lat(B_MODE, 1'b0, lat_mode);
    chk("edit_enter", int'(editing), 1);
    chk("edit_field_g1", int'(edit_field), 0);
    chk("edit_val_g1", int'(edit_val), 25);

    // Three-cycle glitch is rejected.
    @(negedge clk_50M);
    drive(B_UP);
    repeat (3) @(negedge clk_50M);
    drive(4'b0000);
    repeat (12) @(negedge clk_50M);
    chk("glitch", int'(edit_val), 25);

    press(B_UP);
    chk("held_up_once", int'(edit_val), 26);
    press(B_UP); press(B_UP);
    chk("up3", int'(edit_val), 28);
    press(B_MODE);
    chk("field_y1", int'(edit_field), 1);
    chk("val_y1", int'(edit_val), 3);
    press(B_DOWN);
    chk("down_y1", int'(edit_val), 2);
    chk("no_load_in_edit", load_cnt, 0);

    press_lat(B_SAVE, 1'b1, lat_save);
    chk("save_latency", lat_save, lat_mode);
    chk("commit_loads", load_cnt, 1);
    chk("commit_g1", int'(t_g1), 28);
    chk("commit_y1", int'(t_y1), 2);
    chk("commit_g2", int'(t_g2), 20);
    chk("commit_y2", int'(t_y2), 3);
    chk("commit_editing", int'(editing), 0);

    // Wrap at both ends of the legal range.
    press(B_MODE);
    chk("reenter_g1", int'(edit_val), 28);
    press(B_MODE);
    press(B_DOWN);
    chk("y1_to_min", int'(edit_val), 1);
    press(B_DOWN);
    chk("wrap_down", int'(edit_val), 59);
    press(B_UP);
    chk("wrap_up", int'(edit_val), 1);
    press(B_MODE); press(B_MODE); press(B_MODE);
    chk("abort_editing", int'(editing), 0);
    chk("abort_y1_kept", int'(t_y1), 2);
    chk("wrap_no_load", load_cnt, 1);

    press(B_MODE); press(B_UP);
    chk("abort2_val", int'(edit_val), 29);
    press(B_MODE); press(B_MODE); press(B_MODE); press(B_MODE);
    chk("abort2_editing", int'(editing), 0);
    chk("abort2_g1", int'(t_g1), 28);
    chk("abort2_load", load_cnt, 1);

    // Save wins over a simultaneous up.
    press(B_MODE); press(B_MODE); press(B_MODE);
    chk("field_g2", int'(edit_field), 2);
    chk("val_g2", int'(edit_val), 20);
    press(B_UP);
    chk("g2_up", int'(edit_val), 21);
    press(B_UP | B_SAVE);
    chk("simul_g2", int'(t_g2), 21);
    chk("simul_load", load_cnt, 2);
    chk("simul_editing", int'(editing), 0);

    press(B_MODE); press(B_MODE); press(B_MODE); press(B_UP);
    chk("pre_reset_val", int'(edit_val), 22);
    async_reset_check("midedit_rst");
    repeat (2) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50M);
    press(B_MODE);
    chk("post_rst_field", int'(edit_field), 0);
    chk("post_rst_val", int'(edit_val), 25);
    chk("post_rst_load", load_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
